rsa_mont_mult: RTL

Bit-serial radix-2 Montgomery multiplier for the 256-bit RSA datapath. It computes A·B·2^-256 mod N in 257 cycles after a start pulse. It sits directly downstream of the pre-processing stage: it consumes the Montgomery-domain operand T = M·2^256 mod N that stage produces. The exponentiation controller issues its square and multiply operations to this block.

---
 rtl/rsa_mont_mult.sv | 87 ++++++++
 1 files changed

// File: rtl/rsa_mont_mult.sv
// Bit-serial radix-2 Montgomery multiplier: result = A*B*2^-WIDTH mod N.
// One iteration per cycle over the bits of A, then a single conditional subtraction.
module rsa_mont_mult #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] N_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] n_r, a_r, b_r;
  logic [WIDTH+1:0] m, sum_ab, sum_n;
  logic [WIDTH-1:0] m_sub;
  logic [CW-1:0]    i;
  logic             a_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (i == LAST) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // m < 2N, so m - N fits in WIDTH bits whenever the subtraction is taken.
  always_comb begin
    a_bit  = a_r[i[CW-2:0]];
    sum_ab = m + (a_bit ? {2'b00, b_r} : '0);
    sum_n  = sum_ab + (sum_ab[0] ? {2'b00, n_r} : '0);
    m_sub  = m[WIDTH-1:0] - n_r;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_r      <= '0;
      a_r      <= '0;
      b_r      <= '0;
      m        <= '0;
      i        <= '0;
      done     <= 1'b0;
      result_o <= '0;
    end else begin
      done <= (state == FIX);
      unique case (state)
        IDLE: begin
          if (start) begin
            n_r <= N_i;
            a_r <= A_i;
            b_r <= B_i;
            m   <= '0;
            i   <= '0;
          end
        end
        RUN: begin
          m <= sum_n >> 1;
          i <= i + 1'b1;
        end
        FIX: begin
          result_o <= (m >= {2'b00, n_r}) ? m_sub : m[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
